// File: rtl/uart_pkt_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkt_pkg
// Brief    : Shared FSM state type and packet constants for uart_pkt_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND      = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } pkt_state_t;

    localparam int         PKT_BYTES_BASE = 3;
    localparam logic [7:0] DEFAULT_SYNC   = 8'hA5;
    localparam int         BYTE_IDX_W     = 2;

endpackage
`default_nettype wire

// File: rtl/uart_pkt_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkt_scheduler_if
// Brief    : Sample-in / UART-byte-out bundle plus status for the scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_pkt_scheduler_if #(
    parameter int SAMPLE_W = 16
);
    logic [SAMPLE_W-1:0] s_data;
    logic                s_valid;
    logic                s_ready;
    logic [7:0]          tx_data;
    logic                tx_send;
    logic                tx_busy;
    logic                pkt_active;
    logic [15:0]         drop_count;
    logic                err_timeout;

    // master = scheduler side, slave = sample source / transmitter side
    modport master (
        input  s_data, s_valid, tx_busy,
        output s_ready, tx_data, tx_send, pkt_active, drop_count, err_timeout
    );

    modport slave (
        output s_data, s_valid, tx_busy,
        input  s_ready, tx_data, tx_send, pkt_active, drop_count, err_timeout
    );
endinterface
`default_nettype wire

// File: rtl/uart_pkt_scheduler_fifo.sv
`default_nettype none
// ============================================================================
// Module   : pkt_sample_fifo
// Brief    : Synchronous FIFO, async reset, occupancy-based full/empty.
// Revision : 1.0 - initial release
// ============================================================================
module pkt_sample_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     i_push,
    input  wire logic                     i_pop,
    input  wire logic [WIDTH-1:0]         i_wdata,
    output logic      [WIDTH-1:0]         o_rdata,
    output logic                          o_full,
    output logic                          o_empty,
    output logic      [$clog2(DEPTH):0]   o_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] c_CNT_FULL = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == c_CNT_FULL);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/uart_pkt_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkt_scheduler
// Brief    : Frames 16-bit samples as SYNC/MSB/LSB byte packets for a UART TX.
//            Define UART_PKT_CSUM_EN to append a SYNC^MSB^LSB checksum byte.
// Revision : 1.0 - initial release
// ============================================================================
module uart_pkt_scheduler
    import uart_pkt_pkg::*;
#(
    parameter int         SAMPLE_W     = 16,
    parameter int         FIFO_DEPTH   = 4,
    parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC,
    parameter int         BUSY_TIMEOUT = 8
) (
    input  wire logic            clk,
    input  wire logic            rst,
    uart_pkt_scheduler_if.master bus
);
`ifdef UART_PKT_CSUM_EN
    localparam int c_PKT_BYTES = PKT_BYTES_BASE + 1;
`else
    localparam int c_PKT_BYTES = PKT_BYTES_BASE;
`endif
    localparam logic [BYTE_IDX_W-1:0] c_LAST_IDX = BYTE_IDX_W'(c_PKT_BYTES - 1);
    localparam int                    c_TMR_W    = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [c_TMR_W-1:0]    c_TMR_LAST = c_TMR_W'(BUSY_TIMEOUT - 1);
    localparam int                    c_CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [c_CNT_W-1:0]    c_CNT_FULL = c_CNT_W'(FIFO_DEPTH);

    pkt_state_t              r_state,   w_state_nxt;
    logic [BYTE_IDX_W-1:0]   r_idx,     w_idx_nxt;
    logic [c_TMR_W-1:0]      r_tmr,     w_tmr_nxt;
    logic [SAMPLE_W-1:0]     r_sample,  w_sample_nxt;
    logic [7:0]              r_tx_data, w_tx_data_nxt;
    logic                    r_err,     w_err_nxt;
    logic [15:0]             r_drop_cnt;

    logic                    w_pop;
    logic                    w_push;
    logic                    w_drop;
    logic                    w_fifo_full;
    logic                    w_fifo_empty;
    logic [SAMPLE_W-1:0]     w_fifo_rdata;
    logic [c_CNT_W-1:0]      w_fifo_count;

    function automatic logic [7:0] pkt_byte(input logic [BYTE_IDX_W-1:0] idx,
                                            input logic [SAMPLE_W-1:0]   s);
        case (idx)
            2'd0:    return SYNC_BYTE;
            2'd1:    return s[15:8];
            2'd2:    return s[7:0];
`ifdef UART_PKT_CSUM_EN
            default: return SYNC_BYTE ^ s[15:8] ^ s[7:0];
`else
            default: return 8'h00;
`endif
        endcase
    endfunction

    assign w_push = bus.s_valid && (!w_fifo_full || w_pop);
    assign w_drop = bus.s_valid && w_fifo_full && !w_pop;

    pkt_sample_fifo #(
        .WIDTH (SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (bus.s_data),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            r_tmr     <= '0;
            r_sample  <= '0;
            r_tx_data <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_tmr     <= w_tmr_nxt;
            r_sample  <= w_sample_nxt;
            r_tx_data <= w_tx_data_nxt;
            r_err     <= w_err_nxt;
        end
    end

    // r_tmr counts cycles since the tx_send pulse; the last allowed one aborts.
    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_tmr_nxt     = r_tmr;
        w_sample_nxt  = r_sample;
        w_tx_data_nxt = r_tx_data;
        w_err_nxt     = r_err;
        w_pop         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop         = 1'b1;
                    w_sample_nxt  = w_fifo_rdata;
                    w_idx_nxt     = '0;
                    w_tx_data_nxt = SYNC_BYTE;
                    w_state_nxt   = ST_SEND;
                end
            end
            ST_SEND: begin
                w_tmr_nxt   = c_TMR_W'(1);
                w_state_nxt = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    w_state_nxt = ST_WAIT_DONE;
                end else if (r_tmr == c_TMR_LAST) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_tmr_nxt   = r_tmr + 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    if (r_idx != c_LAST_IDX) begin
                        w_idx_nxt     = r_idx + 1'b1;
                        w_tx_data_nxt = pkt_byte(r_idx + 1'b1, r_sample);
                        w_state_nxt   = ST_SEND;
                    end else begin
                        w_state_nxt   = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    assign bus.s_ready     = (w_fifo_count != c_CNT_FULL);
    assign bus.tx_data     = r_tx_data;
    assign bus.tx_send     = (r_state == ST_SEND);
    assign bus.pkt_active  = (r_state != ST_IDLE);
    assign bus.drop_count  = r_drop_cnt;
    assign bus.err_timeout = r_err;
endmodule
`default_nettype wire
